ex_operand_ctrl: RTL and testbench

- EX-stage operand controller for the pipelined core.
- Tracks the destination registers of instructions in the EX, MEM and WB stages.
- Drives the select lines of the ALU operand-A mux (3:1) and operand-B mux (4:1: regfile, MEM forward, WB forward, immediate).
- Detects load-use hazards, freezes the pipe on data-memory wait, and keeps a saturating stall counter.

---
 rtl/ex_ctrl_pkg.sv | 20 ++
 rtl/ex_operand_ctrl_fwd_sel.sv | 31 +++
 rtl/ex_operand_ctrl.sv | 150 +++++++++++++++
 tb/tb_ex_operand_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/ex_ctrl_pkg.sv
// Shared encodings for the EX-stage operand controller: FSM states and operand mux selects.
// No logic; constants and types only.
package ex_ctrl_pkg;

    localparam logic [1:0] S_RUN      = 2'd0;
    localparam logic [1:0] S_LU_STALL = 2'd1;
    localparam logic [1:0] S_FREEZE   = 2'd2;

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b01;
    localparam logic [1:0] SEL_WB  = 2'b10;
    localparam logic [1:0] SEL_IMM = 2'b11;

    typedef enum logic [1:0] {
        ST_RUN      = S_RUN,
        ST_LU_STALL = S_LU_STALL,
        ST_FREEZE   = S_FREEZE
    } state_t;

endpackage

// File: rtl/ex_operand_ctrl_fwd_sel.sv
// Forwarding select for one source operand against the MEM and WB stage records.
// Latency: combinational. Backpressure: none.
module fwd_sel
    import ex_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic                  rs_used,
    input  logic                  mem_valid,
    input  logic                  mem_reg_write,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  wb_valid,
    input  logic                  wb_reg_write,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    output logic [1:0]            sel
);

    always_comb begin
        sel = SEL_RF;
        // x0 is hardwired, so it never takes a forwarded value
        if (rs_used && (rs != '0)) begin
            if (mem_valid && mem_reg_write && (mem_rd == rs)) begin
                sel = SEL_MEM;
            end else if (wb_valid && wb_reg_write && (wb_rd == rs)) begin
                sel = SEL_WB;
            end
        end
    end

endmodule

// File: rtl/ex_operand_ctrl.sv
// EX-stage operand controller: forwarding selects, load-use stall, memory-wait freeze, stall counter.
// Latency: selects come from registered stage records; id_stall/ex_bubble are same-cycle combinational.
// Backpressure: mem_busy freezes all records; a load-use hazard holds ID and injects one bubble.
module ex_operand_ctrl
    import ex_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W  = 5,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   id_valid,
    input  logic [REG_ADDR_W-1:0]  id_rs1,
    input  logic [REG_ADDR_W-1:0]  id_rs2,
    input  logic                   id_rs1_used,
    input  logic                   id_rs2_used,
    input  logic                   id_alu_src,
    input  logic [REG_ADDR_W-1:0]  id_rd,
    input  logic                   id_reg_write,
    input  logic                   id_mem_read,
    input  logic                   mem_busy,
    output logic                   id_stall,
    output logic                   ex_bubble,
    output logic [1:0]             ex_sel_a,
    output logic [1:0]             ex_sel_b,
    output logic [STALL_CNT_W-1:0] stall_count
);

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
        logic                  mem_read;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic                  rs1_used;
        logic                  rs2_used;
        logic                  alu_src;
    } ex_rec_t;

    // Downstream stages only need what the forwarding compare looks at
    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
    } wr_rec_t;

    state_t  state_q, state_d;
    ex_rec_t ex_q, ex_d;
    wr_rec_t mem_q, wb_q;
    logic    shift;
    logic    lu_haz;
    logic [1:0] fwd_a, fwd_b;

    assign lu_haz = ex_q.valid && ex_q.mem_read && ex_q.reg_write && (ex_q.rd != '0) && id_valid &&
                    ((id_rs1_used && (id_rs1 == ex_q.rd)) ||
                     (id_rs2_used && !id_alu_src && (id_rs2 == ex_q.rd)));

    always_comb begin
        state_d   = state_q;
        id_stall  = 1'b0;
        ex_bubble = 1'b0;
        shift     = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (mem_busy) begin
                    state_d  = ST_FREEZE;
                    id_stall = 1'b1;
                end else if (lu_haz) begin
                    state_d   = ST_LU_STALL;
                    id_stall  = 1'b1;
                    ex_bubble = 1'b1;
                    shift     = 1'b1;
                end else begin
                    shift = 1'b1;
                end
            end
            ST_LU_STALL: begin
                shift   = 1'b1;
                state_d = mem_busy ? ST_FREEZE : ST_RUN;
            end
            ST_FREEZE: begin
                id_stall = 1'b1;
                if (!mem_busy) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_comb begin
        ex_d          = '0;
        ex_d.valid    = id_valid && !ex_bubble;
        ex_d.rd       = id_rd;
        ex_d.reg_write = id_reg_write;
        ex_d.mem_read = id_mem_read;
        ex_d.rs1      = id_rs1;
        ex_d.rs2      = id_rs2;
        ex_d.rs1_used = id_rs1_used;
        ex_d.rs2_used = id_rs2_used;
        ex_d.alu_src  = id_alu_src;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_count <= '0;
        end else begin
            state_q <= state_d;
            if (shift) begin
                wb_q  <= mem_q;
                mem_q <= '{valid: ex_q.valid, rd: ex_q.rd, reg_write: ex_q.reg_write};
                ex_q  <= ex_d;
            end
            if (id_stall && (stall_count != '1)) begin
                stall_count <= stall_count + 1'b1;
            end
        end
    end

    fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
        .rs            (ex_q.rs1),
        .rs_used       (ex_q.rs1_used && ex_q.valid),
        .mem_valid     (mem_q.valid),
        .mem_reg_write (mem_q.reg_write),
        .mem_rd        (mem_q.rd),
        .wb_valid      (wb_q.valid),
        .wb_reg_write  (wb_q.reg_write),
        .wb_rd         (wb_q.rd),
        .sel           (fwd_a)
    );

    fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
        .rs            (ex_q.rs2),
        .rs_used       (ex_q.rs2_used && ex_q.valid),
        .mem_valid     (mem_q.valid),
        .mem_reg_write (mem_q.reg_write),
        .mem_rd        (mem_q.rd),
        .wb_valid      (wb_q.valid),
        .wb_reg_write  (wb_q.reg_write),
        .wb_rd         (wb_q.rd),
        .sel           (fwd_b)
    );

    assign ex_sel_a = fwd_a;
    assign ex_sel_b = !ex_q.valid ? SEL_RF : (ex_q.alu_src ? SEL_IMM : fwd_b);

endmodule

// File: tb/tb_ex_operand_ctrl.sv
// Directed bench for ex_operand_ctrl: forwarding, load-use stall, freeze, x0, counter saturation, async reset.
module tb_ex_operand_ctrl;

    localparam int RW = 5;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          id_valid = 1'b0;
    logic [RW-1:0] id_rs1 = '0;
    logic [RW-1:0] id_rs2 = '0;
    logic          id_rs1_used = 1'b0;
    logic          id_rs2_used = 1'b0;
    logic          id_alu_src = 1'b0;
    logic [RW-1:0] id_rd = '0;
    logic          id_reg_write = 1'b0;
    logic          id_mem_read = 1'b0;
    logic          mem_busy = 1'b0;
    logic          id_stall;
    logic          ex_bubble;
    logic [1:0]    ex_sel_a;
    logic [1:0]    ex_sel_b;
    logic [CW-1:0] stall_count;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    ex_operand_ctrl #(.REG_ADDR_W(RW), .STALL_CNT_W(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rs1_used  (id_rs1_used),
        .id_rs2_used  (id_rs2_used),
        .id_alu_src   (id_alu_src),
        .id_rd        (id_rd),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .mem_busy     (mem_busy),
        .id_stall     (id_stall),
        .ex_bubble    (ex_bubble),
        .ex_sel_a     (ex_sel_a),
        .ex_sel_b     (ex_sel_b),
        .stall_count  (stall_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // valid, rs1, rs2, rs1_used, rs2_used, alu_src, rd, reg_write, mem_read
    task automatic set_id(input logic v, input int r1, input int r2, input logic u1, input logic u2,
                          input logic imm, input int rd, input logic rw, input logic mr);
        id_valid     = v;
        id_rs1       = RW'(r1);
        id_rs2       = RW'(r2);
        id_rs1_used  = u1;
        id_rs2_used  = u2;
        id_alu_src   = imm;
        id_rd        = RW'(rd);
        id_reg_write = rw;
        id_mem_read  = mr;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #2;
        check("rst_id_stall", 32'(id_stall), 0);
        check("rst_ex_bubble", 32'(ex_bubble), 0);
        check("rst_sel_a", 32'(ex_sel_a), 0);
        check("rst_sel_b", 32'(ex_sel_b), 0);
        check("rst_count", 32'(stall_count), 0);
        @(negedge clk) rst_n = 1'b1;
        tick();

        // ADD x3 ; SUB x4,x3,x5
        set_id(1, 1, 2, 1, 1, 0, 3, 1, 0);
        check("t1_add_nostall", 32'(id_stall), 0);
        tick();
        set_id(1, 3, 5, 1, 1, 0, 4, 1, 0);
        check("t1_sub_nostall", 32'(id_stall), 0);
        tick();
        check("t1_sel_a_mem", 32'(ex_sel_a), 1);
        check("t1_sel_b_rf", 32'(ex_sel_b), 0);

        // ADD x3 ; NOP ; OR x6,x3,x3
        set_id(1, 1, 2, 1, 1, 0, 3, 1, 0);
        tick();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        set_id(1, 3, 3, 1, 1, 0, 6, 1, 0);
        tick();
        check("t2_sel_a_wb", 32'(ex_sel_a), 2);
        check("t2_sel_b_wb", 32'(ex_sel_b), 2);

        // ADD x3 ; ADD x3 ; OR x6,x3,x3 -> MEM beats WB
        set_id(1, 1, 2, 1, 1, 0, 3, 1, 0);
        tick();
        tick();
        set_id(1, 3, 3, 1, 1, 0, 6, 1, 0);
        tick();
        check("t2_prio_a", 32'(ex_sel_a), 1);
        check("t2_prio_b", 32'(ex_sel_b), 1);

        // LW x7 ; ADD x8,x7,x1
        set_id(1, 1, 0, 1, 0, 1, 7, 1, 1);
        check("t3_lw_nostall", 32'(id_stall), 0);
        tick();
        set_id(1, 7, 1, 1, 1, 0, 8, 1, 0);
        check("t3_stall", 32'(id_stall), 1);
        check("t3_bubble", 32'(ex_bubble), 1);
        check("t3_count0", 32'(stall_count), 0);
        tick();
        check("t3_lus_stall", 32'(id_stall), 0);
        check("t3_lus_bubble", 32'(ex_bubble), 0);
        check("t3_bubble_sel_a", 32'(ex_sel_a), 0);
        check("t3_count1", 32'(stall_count), 1);
        tick();
        check("t3_sel_a_wb", 32'(ex_sel_a), 2);
        check("t3_sel_b_rf", 32'(ex_sel_b), 0);

        // LW x7 ; ADDI x9,x7,imm
        set_id(1, 1, 0, 1, 0, 1, 7, 1, 1);
        tick();
        set_id(1, 7, 0, 1, 0, 1, 9, 1, 0);
        check("t4_rs1_stall", 32'(id_stall), 1);
        tick();
        tick();
        check("t4_sel_a_wb", 32'(ex_sel_a), 2);
        check("t4_sel_b_imm", 32'(ex_sel_b), 3);
        check("t4_count2", 32'(stall_count), 2);

        // LW x7 ; ADDI x2,x1,imm with rs2 field = 7
        set_id(1, 1, 0, 1, 0, 1, 7, 1, 1);
        tick();
        set_id(1, 1, 7, 1, 1, 1, 2, 1, 0);
        check("t4_imm_nostall", 32'(id_stall), 0);
        check("t4_imm_nobubble", 32'(ex_bubble), 0);
        tick();
        check("t4_imm_sel_a", 32'(ex_sel_a), 0);
        check("t4_imm_sel_b", 32'(ex_sel_b), 3);

        // LW x7 ; ADD x8,x7,x1 with mem_busy high for three cycles
        set_id(1, 1, 0, 1, 0, 1, 7, 1, 1);
        tick();
        mem_busy = 1'b1;
        set_id(1, 7, 1, 1, 1, 0, 8, 1, 0);
        check("t5_busy_stall", 32'(id_stall), 1);
        check("t5_busy_nobubble", 32'(ex_bubble), 0);
        tick();
        check("t5_frz1_stall", 32'(id_stall), 1);
        check("t5_frz1_nobubble", 32'(ex_bubble), 0);
        tick();
        check("t5_frz2_nobubble", 32'(ex_bubble), 0);
        tick();
        mem_busy = 1'b0;
        #1;
        check("t5_frz_exit_stall", 32'(id_stall), 1);
        check("t5_frz_exit_nobubble", 32'(ex_bubble), 0);
        tick();
        check("t5_lu_stall", 32'(id_stall), 1);
        check("t5_lu_bubble", 32'(ex_bubble), 1);
        tick();
        check("t5_lus_nostall", 32'(id_stall), 0);
        check("t5_count7", 32'(stall_count), 7);
        tick();
        check("t5_sel_a_wb", 32'(ex_sel_a), 2);

        // ADD x0 ; OR x5,x0,x0 ; LW x0 ; ADD using x0
        set_id(1, 1, 2, 1, 1, 0, 0, 1, 0);
        tick();
        set_id(1, 0, 0, 1, 1, 0, 5, 1, 0);
        tick();
        check("t6_x0_sel_a", 32'(ex_sel_a), 0);
        check("t6_x0_sel_b", 32'(ex_sel_b), 0);
        set_id(1, 1, 0, 1, 0, 1, 0, 1, 1);
        tick();
        set_id(1, 0, 0, 1, 1, 0, 8, 1, 0);
        check("t6_x0_nostall", 32'(id_stall), 0);
        tick();

        // Pending forward, then a long freeze to saturate the counter
        set_id(1, 1, 2, 1, 1, 0, 3, 1, 0);
        tick();
        set_id(1, 3, 3, 1, 1, 0, 6, 1, 0);
        tick();
        check("t6_pre_sel_a", 32'(ex_sel_a), 1);
        mem_busy = 1'b1;
        for (int i = 0; i < 300; i++) tick();
        check("t6_sat_count", 32'(stall_count), 255);
        check("t6_frz_hold_sel_a", 32'(ex_sel_a), 1);
        check("t6_frz_stall", 32'(id_stall), 1);

        // Async reset in the middle of the freeze
        #2;
        mem_busy = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        check("t6_arst_count", 32'(stall_count), 0);
        check("t6_arst_sel_a", 32'(ex_sel_a), 0);
        check("t6_arst_sel_b", 32'(ex_sel_b), 0);
        check("t6_arst_stall", 32'(id_stall), 0);
        check("t6_arst_bubble", 32'(ex_bubble), 0);
        @(negedge clk) rst_n = 1'b1;
        tick();
        check("t6_post_rst_stall", 32'(id_stall), 0);
        check("t6_post_rst_count", 32'(stall_count), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
